// File: rtl/shift_req_pipe_if.sv
// shift_req_pipe_if: request/response handshake bundle for shift_req_pipe
interface shift_req_pipe_if #(
    parameter int DWIDTH = 8
);
    localparam int SDEPTH = $clog2(DWIDTH);

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op;
    logic [SDEPTH-1:0] shamt;
    logic [DWIDTH-1:0] din;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] dout;
    logic              err;

    modport master (
        output in_valid, op, shamt, din, out_ready,
        input  in_ready, out_valid, dout, err
    );

    modport slave (
        input  in_valid, op, shamt, din, out_ready,
        output in_ready, out_valid, dout, err
    );
endinterface

// File: rtl/shift_req_pipe.sv
// shift_req_pipe: one-outstanding shift/rotate request front-end around a shared barrel shifter; optional counters under SHIFT_REQ_PIPE_STATS_EN
module shift_req_pipe #(
    parameter int DWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_req_pipe_if.slave      bus
`ifdef SHIFT_REQ_PIPE_STATS_EN
    ,
    output logic [15:0]          op_cnt,
    output logic [15:0]          err_cnt
`endif
);
    localparam int SDEPTH = $clog2(DWIDTH);
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [SDEPTH-1:0] shamt_q, shamt_d;
    logic [DWIDTH-1:0] din_q, din_d;
    logic [DWIDTH-1:0] tmp_q, tmp_d;
    logic [DWIDTH-1:0] dout_q, dout_d;
    logic              err_q, err_d;

    logic              sh_lr, sh_al;
    logic [SDEPTH-1:0] sh_amt;
    logic [DWIDTH-1:0] sh_sra, sh_res;
    logic              is_rot, is_ill;

    assign is_rot = (op_q == OP_ROL) || (op_q == OP_ROR);
    assign is_ill = op_q > OP_ROR;

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == RESP;
    assign bus.dout      = dout_q;
    assign bus.err       = err_q;

    // Shared shifter: first pass follows the opcode, second pass shifts the opposite way by the complement amount
    always_comb begin
        sh_lr  = (op_q == OP_SRL) || (op_q == OP_SRA) || (op_q == OP_ROR && shamt_q != '0);
        sh_al  = op_q == OP_SRA;
        sh_amt = shamt_q;
        if (state_q == PASS2) begin
            sh_lr  = op_q == OP_ROL;
            sh_al  = 1'b0;
            sh_amt = SDEPTH'(DWIDTH - int'(shamt_q));
        end
        sh_sra = $signed(din_q) >>> sh_amt;
        sh_res = !sh_lr ? din_q << sh_amt : sh_al ? sh_sra : din_q >> sh_amt;
    end

    // Next-state and datapath updates; request regs only load on acceptance so they stay stable until completion
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        shamt_d = shamt_q;
        din_d   = din_q;
        tmp_d   = tmp_q;
        dout_d  = dout_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.op;
                    shamt_d = bus.shamt;
                    din_d   = bus.din;
                    state_d = PASS1;
                end
            end
            PASS1: begin
                state_d = RESP;
                if (is_ill) begin
                    dout_d = din_q;
                    err_d  = 1'b1;
                end else if (is_rot && shamt_q != '0) begin
                    tmp_d   = sh_res;
                    state_d = PASS2;
                end else begin
                    dout_d = sh_res;
                end
            end
            PASS2: begin
                dout_d  = tmp_q | sh_res;
                state_d = RESP;
            end
            RESP: begin
                if (bus.out_ready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            shamt_q <= '0;
            din_q   <= '0;
            tmp_q   <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            shamt_q <= shamt_d;
            din_q   <= din_d;
            tmp_q   <= tmp_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

`ifdef SHIFT_REQ_PIPE_STATS_EN
    logic [15:0] op_cnt_q, err_cnt_q;

    assign op_cnt  = op_cnt_q;
    assign err_cnt = err_cnt_q;

    // Saturating counts of completed responses and of those flagged illegal
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            if (op_cnt_q != 16'hFFFF) op_cnt_q <= op_cnt_q + 16'd1;
            if (err_q && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_shift_req_pipe.sv
// tb_shift_req_pipe: directed and randomized checks of shift_req_pipe
module tb_shift_req_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   hs_cnt = 0;
    int   ill_cnt = 0;

    shift_req_pipe_if #(.DWIDTH(8)) bus ();

`ifdef SHIFT_REQ_PIPE_STATS_EN
    logic [15:0] op_cnt, err_cnt;
    shift_req_pipe #(.DWIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .op_cnt(op_cnt), .err_cnt(err_cnt));
`else
    shift_req_pipe #(.DWIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] model(input logic [2:0] o, input logic [2:0] s, input logic [7:0] d);
        logic [15:0] w;
        logic [7:0]  r;
        r = d;
        case (o)
            3'd0: r = d << s;
            3'd1: r = d >> s;
            3'd2: begin w = {{8{d[7]}}, d} >> s; r = w[7:0]; end
            3'd3: for (int i = 0; i < 8; i++) r[(i + int'(s)) % 8] = d[i];
            3'd4: for (int i = 0; i < 8; i++) r[i] = d[(i + int'(s)) % 8];
            default: return {1'b1, d};
        endcase
        return {1'b0, r};
    endfunction

    // Issue one request from IDLE; lat counts edges from the handshake cycle to out_valid (20 = timed out)
    task automatic send(input logic [2:0] o, input logic [2:0] s, input logic [7:0] d, output int lat);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.shamt = s;
        bus.din = d;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op = 3'($urandom);
        bus.shamt = 3'($urandom);
        bus.din = 8'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_resp(input logic e);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        hs_cnt++;
        if (e) ill_cnt++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.op = '0;
        bus.shamt = '0;
        bus.din = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++;
        if (bus.dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", bus.dout); end
        n_cmp++;
        if (bus.err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", bus.err); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_sra;
        int lat;
        send(3'd2, 3'd3, 8'h96, lat);
        n_cmp++;
        if (lat !== 2) begin n_err++; $display("FAIL sra_latency: got %0d want 2", lat); end
        n_cmp++;
        if (bus.dout !== 8'hF2) begin n_err++; $display("FAIL sra_dout: got %h want f2", bus.dout); end
        n_cmp++;
        if (bus.err !== 1'b0) begin n_err++; $display("FAIL sra_err: got %b want 0", bus.err); end
        release_resp(1'b0);
    endtask

    task automatic test_rotate;
        int lat;
        send(3'd3, 3'd1, 8'h81, lat);
        n_cmp++;
        if (lat !== 3) begin n_err++; $display("FAIL rol_latency: got %0d want 3", lat); end
        n_cmp++;
        if (bus.dout !== 8'h03) begin n_err++; $display("FAIL rol_dout: got %h want 03", bus.dout); end
        release_resp(1'b0);
        send(3'd4, 3'd1, 8'h81, lat);
        n_cmp++;
        if (lat !== 3) begin n_err++; $display("FAIL ror_latency: got %0d want 3", lat); end
        n_cmp++;
        if (bus.dout !== 8'hC0) begin n_err++; $display("FAIL ror_dout: got %h want c0", bus.dout); end
        release_resp(1'b0);
    endtask

    task automatic test_zero_and_illegal;
        int lat;
        send(3'd4, 3'd0, 8'h5A, lat);
        n_cmp++;
        if (lat !== 2) begin n_err++; $display("FAIL ror0_latency: got %0d want 2", lat); end
        n_cmp++;
        if (bus.dout !== 8'h5A) begin n_err++; $display("FAIL ror0_dout: got %h want 5a", bus.dout); end
        release_resp(1'b0);
        send(3'd6, 3'd5, 8'h3C, lat);
        n_cmp++;
        if (lat !== 2) begin n_err++; $display("FAIL illegal_latency: got %0d want 2", lat); end
        n_cmp++;
        if (bus.dout !== 8'h3C || bus.err !== 1'b1) begin
            n_err++; $display("FAIL illegal_result: got dout=%h err=%b want 3c/1", bus.dout, bus.err);
        end
        release_resp(1'b1);
        n_cmp++;
        if (bus.err !== 1'b0 || bus.out_valid !== 1'b0 || bus.dout !== 8'h3C) begin
            n_err++; $display("FAIL after_handshake: got err=%b valid=%b dout=%h want 0/0/3c", bus.err, bus.out_valid, bus.dout);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        send(3'd0, 3'd7, 8'h01, lat);
        n_cmp++;
        if (lat !== 2 || bus.dout !== 8'h80) begin
            n_err++; $display("FAIL bp_first: got lat=%0d dout=%h want 2/80", lat, bus.dout);
        end
        bus.in_valid = 1'b1;
        bus.op = 3'd1;
        bus.shamt = 3'd4;
        bus.din = 8'h80;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.dout !== 8'h80 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                n_err++; $display("FAIL bp_stall%0d: got dout=%h ready=%b valid=%b want 80/0/1", c, bus.dout, bus.in_ready, bus.out_valid);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        hs_cnt++;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_release: got ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_accept: got in_ready=%b want 0", bus.in_ready); end
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat !== 2 || bus.dout !== 8'h08) begin
            n_err++; $display("FAIL bp_second: got lat=%0d dout=%h want 2/08", lat, bus.dout);
        end
        release_resp(1'b0);
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        @(negedge clk);
        bus.op = 3'd0;
        bus.shamt = 3'd2;
        bus.din = 8'h03;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                pulses++;
                hs_cnt++;
                n_cmp++;
                if (bus.dout !== 8'h0C) begin n_err++; $display("FAIL b2b_dout: got %h want 0c", bus.dout); end
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (pulses !== 3) begin n_err++; $display("FAIL b2b_rate: got %0d results want 3 in 9 cycles", pulses); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_rotate;
        logic seen = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = 3'd3;
        bus.shamt = 3'd1;
        bus.din = 8'h81;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        hs_cnt = 0;
        ill_cnt = 0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.dout !== 8'h00) begin
            n_err++; $display("FAIL midrst_values: got valid=%b dout=%h want 0/00", bus.out_valid, bus.dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", bus.in_ready); end
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_ghost: got out_valid during idle want none"); end
    endtask

    task automatic test_random;
        logic [2:0] o, s;
        logic [7:0] d, held;
        logic [8:0] exp;
        int k, stall;
        for (int i = 0; i < 2000; i++) begin
            o = 3'($urandom_range(0, 7));
            s = 3'($urandom_range(0, 7));
            d = 8'($urandom);
            exp = model(o, s, d);
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.op = o;
            bus.shamt = s;
            bus.din = d;
            bus.out_ready = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.din = 8'($urandom);
            k = 0;
            while (!bus.out_valid && k < 10) begin
                bus.out_ready = 1'($urandom);
                @(negedge clk);
                k++;
            end
            bus.out_ready = 1'b0;
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.dout !== exp[7:0] || bus.err !== exp[8]) begin
                n_err++; $display("FAIL rand%0d op=%0d sh=%0d din=%h: got v=%b dout=%h err=%b want 1/%h/%b", i, o, s, d, bus.out_valid, bus.dout, bus.err, exp[7:0], exp[8]);
            end
            held = bus.dout;
            stall = $urandom_range(0, 3);
            for (int c = 0; c < stall; c++) begin
                @(negedge clk);
                n_cmp++;
                if (bus.dout !== held || bus.out_valid !== 1'b1) begin
                    n_err++; $display("FAIL rand_hold%0d: got dout=%h v=%b want %h/1", i, bus.dout, bus.out_valid, held);
                end
            end
            release_resp(exp[8]);
        end
    endtask

    task automatic test_stats;
`ifdef SHIFT_REQ_PIPE_STATS_EN
        n_cmp++;
        if (op_cnt !== 16'(hs_cnt)) begin n_err++; $display("FAIL stats_op_cnt: got %0d want %0d", op_cnt, hs_cnt); end
        n_cmp++;
        if (err_cnt !== 16'(ill_cnt)) begin n_err++; $display("FAIL stats_err_cnt: got %0d want %0d", err_cnt, ill_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_sra();
        test_rotate();
        test_zero_and_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_rotate();
        test_random();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
